// File: rtl/retire_stage_pkg.sv
// Shared types for the retire stage: ROB retire packet, stage state enum and sizing.
`ifndef PR
`define PR 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

package retire_stage_pkg;

    localparam int unsigned RETIRE_W  = 3;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned AREG_W    = 5;
    localparam int unsigned PR_W      = `PR;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned INC_W     = 2;

    typedef struct packed {
        logic               valid;
        logic [AREG_W-1:0]  arch_reg;
        logic [`PR-1:0]     tnew;
        logic [`PR-1:0]     told;
        logic               halt;
        logic               precise_state_need;
        logic [`XLEN-1:0]   target_pc;
        logic               completed;
    } rob_entry_packet_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } retire_state_e;

    // Number of committing slots in one group.
    function automatic logic [INC_W-1:0] count_commits(input logic [RETIRE_W-1:0] v);
        logic [INC_W-1:0] n;
        n = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            n = n + INC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/retire_stage_if.sv
// ROB-to-retire bus plus the commit/recovery outputs the stage drives back out.
interface retire_stage_if;
    import retire_stage_pkg::*;

    rob_entry_packet_t [RETIRE_W-1:0]             retire_entry;
    logic [RETIRE_W-1:0]                          free_valid;
    logic [RETIRE_W-1:0][`PR-1:0]                 free_pr;
    logic                                         squash;
    logic [`XLEN-1:0]                             squash_pc;
    logic [ARCH_REGS-1:0][`PR-1:0]                amt_out;
    logic                                         halt;
    logic [CNT_W-1:0]                             retire_cnt;

    modport master (
        output retire_entry,
        input  free_valid, free_pr, squash, squash_pc, amt_out, halt, retire_cnt
    );

    modport slave (
        input  retire_entry,
        output free_valid, free_pr, squash, squash_pc, amt_out, halt, retire_cnt
    );
endinterface

// File: rtl/retire_stage_amt.sv
// Architectural map table: identity at reset, ordered write ports where the lowest index (youngest) wins.
module arch_map_table
    import retire_stage_pkg::*;
(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [RETIRE_W-1:0]                  we,
    input  logic [RETIRE_W-1:0][AREG_W-1:0]      waddr,
    input  logic [RETIRE_W-1:0][`PR-1:0]         wdata,
    output logic [ARCH_REGS-1:0][`PR-1:0]        amt
);

    // Oldest port applied first so a younger write to the same register lands last.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                amt[r] <= PR_W'(r);
            end
        end else begin
            for (int i = RETIRE_W - 1; i >= 0; i--) begin
                if (we[i]) begin
                    amt[waddr[i]] <= wdata[i];
                end
            end
        end
    end

endmodule

// File: rtl/retire_stage.sv
// Three-wide in-order commit stage: registers the ROB retire group, commits oldest-first,
// updates the AMT, frees old physical registers and raises squash/halt.
module retire_stage
    import retire_stage_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    retire_stage_if.slave  rif
);

    retire_state_e                         state;
    retire_state_e                         next_state;
    rob_entry_packet_t [RETIRE_W-1:0]      grp;
    logic [CNT_W-1:0]                      retire_cnt;

    logic [RETIRE_W-1:0]                   commit_c;
    logic [RETIRE_W-1:0]                   free_valid_c;
    logic [RETIRE_W-1:0][`PR-1:0]          free_pr_c;
    logic [RETIRE_W-1:0][AREG_W-1:0]       waddr_c;
    logic [RETIRE_W-1:0][`PR-1:0]          wdata_c;
    logic                                  blocked_c;
    logic                                  squash_c;
    logic                                  halt_hit_c;
    logic [`XLEN-1:0]                      squash_pc_c;
    logic [RETIRE_W-1:0]                   unused_completed;

    // Commit scan, slot 2 (oldest) down to 0; a committed halt/mispredict discards younger slots.
    always_comb begin
        commit_c         = '0;
        free_valid_c     = '0;
        free_pr_c        = '0;
        waddr_c          = '0;
        wdata_c          = '0;
        blocked_c        = 1'b0;
        squash_c         = 1'b0;
        halt_hit_c       = 1'b0;
        squash_pc_c      = '0;
        unused_completed = '0;
        for (int i = RETIRE_W - 1; i >= 0; i--) begin
            waddr_c[i]          = grp[i].arch_reg;
            wdata_c[i]          = grp[i].tnew;
            unused_completed[i] = grp[i].completed;
            if ((state == RUN) && grp[i].valid && !blocked_c) begin
                commit_c[i] = 1'b1;
                if (grp[i].arch_reg != '0) begin
                    free_valid_c[i] = 1'b1;
                    free_pr_c[i]    = grp[i].told;
                end
                if (grp[i].halt) begin
                    halt_hit_c = 1'b1;
                    blocked_c  = 1'b1;
                end else if (grp[i].precise_state_need) begin
                    squash_c    = 1'b1;
                    squash_pc_c = grp[i].target_pc;
                    blocked_c   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (halt_hit_c) begin
                    next_state = HALTED;
                end else if (squash_c) begin
                    next_state = RECOVER;
                end
            end
            RECOVER: next_state = RUN;
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // The group arriving while we leave RUN belongs to the flushed path and is dropped.
    always_ff @(posedge clock) begin
        if (reset || (next_state != RUN)) begin
            grp <= '0;
        end else begin
            grp <= rif.retire_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retire_cnt <= '0;
        end else begin
            retire_cnt <= retire_cnt + CNT_W'(count_commits(commit_c));
        end
    end

    arch_map_table u_amt (
        .clock (clock),
        .reset (reset),
        .we    (free_valid_c),
        .waddr (waddr_c),
        .wdata (wdata_c),
        .amt   (rif.amt_out)
    );

    assign rif.free_valid = free_valid_c;
    assign rif.free_pr    = free_pr_c;
    assign rif.squash     = squash_c;
    assign rif.squash_pc  = squash_pc_c;
    assign rif.halt       = (state == HALTED);
    assign rif.retire_cnt = retire_cnt;

endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: commit, collision, x0, mispredict, halt and reset-in-recover.
module tb_retire_stage;
    import retire_stage_pkg::*;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    retire_stage_if rif ();

    retire_stage dut (
        .clock (clock),
        .reset (reset),
        .rif   (rif.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic rob_entry_packet_t mk(input logic [4:0] areg, input int unsigned told,
                                             input int unsigned tnew, input logic hlt,
                                             input logic psn, input logic [31:0] pc);
        rob_entry_packet_t e;
        e                    = '0;
        e.valid              = 1'b1;
        e.arch_reg           = areg;
        e.told               = PR_W'(told);
        e.tnew               = PR_W'(tnew);
        e.halt               = hlt;
        e.precise_state_need = psn;
        e.target_pc          = pc;
        e.completed          = 1'b1;
        return e;
    endfunction

    task automatic put(input rob_entry_packet_t s2, input rob_entry_packet_t s1,
                       input rob_entry_packet_t s0);
        rif.retire_entry[2] = s2;
        rif.retire_entry[1] = s1;
        rif.retire_entry[0] = s0;
    endtask

    initial begin
        rob_entry_packet_t none;
        none  = '0;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        rif.retire_entry = '0;
        step();
        step();
        reset = 1'b0;

        check_eq("rst_amt5", 64'(rif.amt_out[5]), 64'd5);
        check_eq("rst_halt", 64'(rif.halt), 64'd0);
        check_eq("rst_cnt", 64'(rif.retire_cnt), 64'd0);
        check_eq("rst_free", 64'(rif.free_valid), 64'd0);
        check_eq("rst_squash", 64'(rif.squash), 64'd0);

        // Full group of three
        put(mk(5'd1, 33, 40, 0, 0, 0), mk(5'd2, 34, 41, 0, 0, 0), mk(5'd3, 35, 42, 0, 0, 0));
        step();
        put(none, none, none);
        check_eq("g3_fv", 64'(rif.free_valid), 64'b111);
        check_eq("g3_fpr0", 64'(rif.free_pr[0]), 64'd35);
        check_eq("g3_fpr1", 64'(rif.free_pr[1]), 64'd34);
        check_eq("g3_fpr2", 64'(rif.free_pr[2]), 64'd33);
        check_eq("g3_amt1_pre", 64'(rif.amt_out[1]), 64'd1);
        step();
        check_eq("g3_amt1", 64'(rif.amt_out[1]), 64'd40);
        check_eq("g3_amt2", 64'(rif.amt_out[2]), 64'd41);
        check_eq("g3_amt3", 64'(rif.amt_out[3]), 64'd42);
        check_eq("g3_cnt", 64'(rif.retire_cnt), 64'd3);
        check_eq("g3_fv_idle", 64'(rif.free_valid), 64'd0);

        // Same-register collision, younger slot wins
        put(mk(5'd4, 36, 50, 0, 0, 0), mk(5'd4, 37, 51, 0, 0, 0), none);
        step();
        put(none, none, none);
        check_eq("col_fv", 64'(rif.free_valid), 64'b110);
        check_eq("col_fpr2", 64'(rif.free_pr[2]), 64'd36);
        check_eq("col_fpr1", 64'(rif.free_pr[1]), 64'd37);
        step();
        check_eq("col_amt4", 64'(rif.amt_out[4]), 64'd51);
        check_eq("col_cnt", 64'(rif.retire_cnt), 64'd5);

        // x0 destination
        put(mk(5'd0, 38, 52, 0, 0, 0), none, none);
        step();
        put(none, none, none);
        check_eq("x0_fv", 64'(rif.free_valid), 64'd0);
        step();
        check_eq("x0_amt0", 64'(rif.amt_out[0]), 64'd0);
        check_eq("x0_cnt", 64'(rif.retire_cnt), 64'd6);

        // Mispredict on slot 1
        put(mk(5'd5, 39, 53, 0, 0, 0), mk(5'd6, 43, 54, 0, 1, 32'h100), mk(5'd7, 44, 55, 0, 0, 0));
        step();
        put(mk(5'd8, 45, 56, 0, 0, 0), none, none);
        check_eq("mp_squash", 64'(rif.squash), 64'd1);
        check_eq("mp_pc", 64'(rif.squash_pc), 64'h100);
        check_eq("mp_fv", 64'(rif.free_valid), 64'b110);
        check_eq("mp_amt6_pre", 64'(rif.amt_out[6]), 64'd6);
        step();
        put(mk(5'd9, 46, 57, 0, 0, 0), none, none);
        check_eq("rc_squash", 64'(rif.squash), 64'd0);
        check_eq("rc_fv", 64'(rif.free_valid), 64'd0);
        check_eq("rc_amt5", 64'(rif.amt_out[5]), 64'd53);
        check_eq("rc_amt6", 64'(rif.amt_out[6]), 64'd54);
        check_eq("rc_amt7", 64'(rif.amt_out[7]), 64'd7);
        check_eq("rc_cnt", 64'(rif.retire_cnt), 64'd8);
        step();
        put(none, none, none);
        check_eq("resume_fv", 64'(rif.free_valid), 64'b100);
        check_eq("resume_fpr2", 64'(rif.free_pr[2]), 64'd46);
        step();
        check_eq("resume_amt8", 64'(rif.amt_out[8]), 64'd8);
        check_eq("resume_amt9", 64'(rif.amt_out[9]), 64'd57);
        check_eq("resume_cnt", 64'(rif.retire_cnt), 64'd9);

        // Reset arriving during RECOVER
        put(mk(5'd10, 47, 58, 0, 1, 32'h200), none, none);
        step();
        put(none, none, none);
        check_eq("mp2_squash", 64'(rif.squash), 64'd1);
        check_eq("mp2_pc", 64'(rif.squash_pc), 64'h200);
        step();
        check_eq("mp2_amt10", 64'(rif.amt_out[10]), 64'd58);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rr_squash", 64'(rif.squash), 64'd0);
        check_eq("rr_amt10", 64'(rif.amt_out[10]), 64'd10);
        check_eq("rr_amt1", 64'(rif.amt_out[1]), 64'd1);
        check_eq("rr_cnt", 64'(rif.retire_cnt), 64'd0);
        put(mk(5'd1, 2, 60, 0, 0, 0), none, none);
        step();
        put(none, none, none);
        check_eq("rr_run_fv", 64'(rif.free_valid), 64'b100);
        step();
        check_eq("rr_run_amt1", 64'(rif.amt_out[1]), 64'd60);
        check_eq("rr_run_cnt", 64'(rif.retire_cnt), 64'd1);

        // Halt on oldest slot, also flagged mispredict: halt wins
        put(mk(5'd2, 3, 61, 1, 1, 32'h300), mk(5'd3, 4, 62, 0, 0, 0), mk(5'd4, 5, 63, 0, 0, 0));
        step();
        put(mk(5'd5, 6, 63, 0, 0, 0), none, none);
        check_eq("h_fv", 64'(rif.free_valid), 64'b100);
        check_eq("h_squash", 64'(rif.squash), 64'd0);
        step();
        check_eq("h_halt", 64'(rif.halt), 64'd1);
        check_eq("h_fv_after", 64'(rif.free_valid), 64'd0);
        check_eq("h_cnt", 64'(rif.retire_cnt), 64'd2);
        check_eq("h_amt2", 64'(rif.amt_out[2]), 64'd61);
        check_eq("h_amt3", 64'(rif.amt_out[3]), 64'd3);
        step();
        put(none, none, none);
        check_eq("h_sticky", 64'(rif.halt), 64'd1);
        check_eq("h_fv_frozen", 64'(rif.free_valid), 64'd0);
        check_eq("h_cnt_frozen", 64'(rif.retire_cnt), 64'd2);
        check_eq("h_amt5", 64'(rif.amt_out[5]), 64'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("h_rst_halt", 64'(rif.halt), 64'd0);
        check_eq("h_rst_cnt", 64'(rif.retire_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
